unidad_logica_reg: RTL
======================

UNIDAD_LOGICA_REG -- requirements
Module: unidad_logica_reg

Interface
REQ-001 Parameter ANCHO, default 8; operand and result width in bits, legal range 1..64.
REQ-002 Parameter CONT_ANCHO, default 16; width of the accepted-operation counter.
REQ-003 reloj  input  1  single clock; all state updates on the rising edge.
REQ-004 reinicio  input  1  asynchronous, active-high reset.
REQ-005 entradaA  input  ANCHO  operand A.
REQ-006 entradaB  input  ANCHO  operand B.
REQ-007 operacion  input  3  opcode: 000 AND, 001 NAND, 010 OR, 011 NOR, 100 NOT A, 101 XOR, 110 XNOR, 111 PASS A.
REQ-008 entradaValida  input  1  producer presents a valid operand/opcode set.
REQ-009 entradaLista  output  1  block can accept an operation this cycle.
REQ-010 salida  output  ANCHO  bitwise result at the head of the output buffer.
REQ-011 salidaValida  output  1  salida and cero hold a valid result.
REQ-012 salidaLista  input  1  consumer accepts the head result.
REQ-013 cero  output  1  high when the head result is all zeros.
REQ-014 contadorOps  output  CONT_ANCHO  count of accepted operations; present only with the macro defined (REQ-031).

Function
REQ-015 An operation SHALL be accepted on a rising edge where entradaValida && entradaLista; the result SHALL be computed bitwise over all ANCHO bits from the operands sampled on that edge.
REQ-016 A result SHALL be consumed on a rising edge where salidaValida && salidaLista.
REQ-017 Results SHALL be held in a 2-entry in-order buffer; states VACIO (0 entries), UNO (1), LLENO (2).
REQ-018 Transitions: VACIO->UNO on accept; UNO->LLENO on accept without consume; UNO->VACIO on consume without accept; LLENO->UNO on consume; UNO stays UNO on simultaneous accept and consume.
REQ-019 entradaLista SHALL be high in VACIO and UNO and low in LLENO; it SHALL be combinationally independent of entradaValida.
REQ-020 salidaValida SHALL be high exactly in UNO and LLENO; latency from accept to salidaValida is 1 cycle when the buffer is VACIO.
REQ-021 While salidaValida is high and salidaLista is low, salida and cero SHALL hold their values stable.
REQ-022 cero SHALL equal the NOR-reduction of the registered head result, never of the live inputs.
REQ-023 In LLENO, entradaValida SHALL be ignored and SHALL NOT corrupt buffered results.
REQ-024 Result ordering SHALL be strictly FIFO; no result is dropped or duplicated under any valid/ready pattern.
REQ-025 With the macro defined, contadorOps SHALL increment by 1 on every accept and wrap from 2^CONT_ANCHO-1 to 0.

Reset
REQ-026 reinicio high SHALL immediately force state VACIO, entradaLista=0 while asserted, salidaValida=0, salida=0, cero=1, contadorOps=0.
REQ-027 After reinicio deasserts, entradaLista SHALL be high from the first rising edge onward.
REQ-028 Reset asserted mid-operation SHALL discard all buffered results; no result produced before reset SHALL appear after it.

Configuration
REQ-029 Macro UNIDAD_LOGICA_CONTADOR_EN SHALL control the operation counter.
REQ-030 Without the macro: no counter register and no contadorOps port; all other behaviour unchanged.
REQ-031 With the macro: contadorOps port and counter exist per REQ-025 and REQ-026.

Verification (ANCHO=8, CONT_ANCHO=16)
REQ-032 A=0xF0, B=0x3C, each opcode 000..111 in turn, salidaLista=1 -> salida = 0x30, 0xCF, 0xFC, 0x03, 0x0F, 0xCC, 0x33, 0xF0, one per cycle, each 1 cycle after accept.
REQ-033 salidaLista=0, three back-to-back valid ops -> two accepted, entradaLista=0 after the second, third held by the producer; raising salidaLista drains results in order, then the third is accepted.
REQ-034 UNO state, simultaneous accept and consume for 10 cycles -> buffer stays UNO, entradaLista stays 1, ten results out in order.
REQ-035 A=0xAA, B=0x55, opcode 000 -> salida=0x00, cero=1; opcode 010 -> salida=0xFF, cero=0.
REQ-036 LLENO state, pulse reinicio -> salidaValida=0, salida=0, cero=1 immediately; no pre-reset result emitted afterward.
REQ-037 Macro defined, counter preloaded near wrap via 65537 accepts -> contadorOps=1; macro undefined -> elaboration has no contadorOps port.

Source files
------------

// File: rtl/unidad_logica_reg.sv
// unidad_logica_reg: bitwise logic unit with a 2-entry in-order result buffer
// and valid/ready handshakes on both sides.
// Optional feature: define UNIDAD_LOGICA_CONTADOR_EN to add the contadorOps
// port and its accepted-operation counter.
//
// state | meaning
// VACIO | no result buffered
// UNO   | one result buffered (head valid)
// LLENO | two results buffered, producer stalled
module unidad_logica_reg #(
  parameter int ANCHO      = 8,
  parameter int CONT_ANCHO = 16
) (
  input  logic                  reloj,
  input  logic                  reinicio,
  input  logic [ANCHO-1:0]      entradaA,
  input  logic [ANCHO-1:0]      entradaB,
  input  logic [2:0]            operacion,
  input  logic                  entradaValida,
  output logic                  entradaLista,
  output logic [ANCHO-1:0]      salida,
  output logic                  salidaValida,
  input  logic                  salidaLista,
  output logic                  cero
`ifdef UNIDAD_LOGICA_CONTADOR_EN
  ,
  output logic [CONT_ANCHO-1:0] contadorOps
`endif
);

  typedef enum logic [1:0] {
    VACIO = 2'd0,
    UNO   = 2'd1,
    LLENO = 2'd2
  } estado_t;

  estado_t          estado, estado_sig;
  logic [ANCHO-1:0] cabeza, cabeza_sig;
  logic [ANCHO-1:0] cola, cola_sig;
  logic [ANCHO-1:0] resultado;
  logic             entrada_lista_q;
  logic             salida_valida_q;
  logic             cero_q;
  logic             acepta;
  logic             consume;

  assign entradaLista = entrada_lista_q;
  assign salidaValida = salida_valida_q;
  assign salida       = cabeza;
  assign cero         = cero_q;

  assign acepta  = entradaValida && entrada_lista_q;
  assign consume = salida_valida_q && salidaLista;

  // Bitwise result of the operands presented this cycle.
  always_comb begin
    resultado = '0;
    case (operacion)
      3'b000:  resultado = entradaA & entradaB;
      3'b001:  resultado = ~(entradaA & entradaB);
      3'b010:  resultado = entradaA | entradaB;
      3'b011:  resultado = ~(entradaA | entradaB);
      3'b100:  resultado = ~entradaA;
      3'b101:  resultado = entradaA ^ entradaB;
      3'b110:  resultado = ~(entradaA ^ entradaB);
      default: resultado = entradaA;
    endcase
  end

  // Buffer occupancy and slot contents for the next cycle.
  always_comb begin
    estado_sig = estado;
    cabeza_sig = cabeza;
    cola_sig   = cola;
    case (estado)
      VACIO: begin
        if (acepta) begin
          cabeza_sig = resultado;
          estado_sig = UNO;
        end
      end
      UNO: begin
        if (acepta && consume) begin
          cabeza_sig = resultado;
        end else if (acepta) begin
          cola_sig   = resultado;
          estado_sig = LLENO;
        end else if (consume) begin
          estado_sig = VACIO;
        end
      end
      LLENO: begin
        // entradaLista is low here, so only a consume can move the buffer.
        if (consume) begin
          cabeza_sig = cola;
          estado_sig = UNO;
        end
      end
      default: estado_sig = VACIO;
    endcase
  end

  // State, slots and registered handshake/flag outputs.
  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      estado          <= VACIO;
      cabeza          <= '0;
      cola            <= '0;
      entrada_lista_q <= 1'b0;
      salida_valida_q <= 1'b0;
      cero_q          <= 1'b1;
    end else begin
      estado          <= estado_sig;
      cabeza          <= cabeza_sig;
      cola            <= cola_sig;
      entrada_lista_q <= (estado_sig != LLENO);
      salida_valida_q <= (estado_sig != VACIO);
      cero_q          <= ~|cabeza_sig;
    end
  end

`ifdef UNIDAD_LOGICA_CONTADOR_EN
  // Count accepted operations, wrapping naturally at full scale.
  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      contadorOps <= '0;
    end else if (acepta) begin
      contadorOps <= contadorOps + 1'b1;
    end
  end
`endif

endmodule
